// File: rtl/lcd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sequencer_if
// Description : Host-side frame-buffer/refresh signals and the byte handshake
//               to the downstream nibble writer, bundled for lcd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_sequencer_if;
  logic       char_we;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       refresh;
  logic       wr_busy;
  logic       wr_strb;
  logic [7:0] wr_data;
  logic       wr_rs;
  logic       ready;
  logic       timeout;

  // Sequencer side
  modport master (
    input  char_we, char_addr, char_data, refresh, wr_busy,
    output wr_strb, wr_data, wr_rs, ready, timeout
  );

  // Host / writer side
  modport slave (
    output char_we, char_addr, char_data, refresh, wr_busy,
    input  wr_strb, wr_data, wr_rs, ready, timeout
  );
endinterface
`default_nettype wire

// File: rtl/lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sequencer
// Description : Drives a 2x16 character LCD through a byte-level nibble
//               writer: power-up wait, init command string, then redraws a
//               32-entry frame buffer on request. Optional build macro
//               LCD_SEQ_AUTO_REFRESH_EN makes frames redraw continuously.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_sequencer #(
  parameter int PWRUP_DLY = 405000,
  parameter int TO_CYCLES = 131071
) (
  input wire             Clk,
  input wire             Reset,
  lcd_sequencer_if.master bus
);

  localparam int c_PWR_W = (PWRUP_DLY > 1) ? $clog2(PWRUP_DLY) : 1;
  localparam int c_TO_W  = $clog2(TO_CYCLES + 1);
  localparam logic [c_PWR_W-1:0] c_PWR_LAST = c_PWR_W'(PWRUP_DLY - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    INIT  = 3'd1,
    IDLE  = 3'd2,
    ADDR1 = 3'd3,
    LINE1 = 3'd4,
    ADDR2 = 3'd5,
    LINE2 = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_SEND    = 2'd0,
    PH_WAIT_HI = 2'd1,
    PH_WAIT_LO = 2'd2
  } phase_t;

  state_t             r_state, w_state_nxt;
  phase_t             r_phase, w_phase_nxt;
  logic [c_PWR_W-1:0] r_pwr_cnt, w_pwr_cnt_nxt;
  logic [c_TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic [2:0]         r_init_idx, w_init_idx_nxt;
  logic [4:0]         r_char_idx, w_char_idx_nxt;
  logic               r_wr_strb, w_strb_nxt;
  logic [7:0]         r_wr_data, w_data_nxt;
  logic               r_wr_rs, w_rs_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_pending, w_pending_nxt;
  logic               r_rdy_pulse, w_rdy_pulse_nxt;
  logic               w_byte_done;
  logic               w_sending;
  logic [7:0]         w_tx_byte;
  logic               w_tx_rs;

  logic [7:0]         r_buf [32];

  // Frame buffer: host writes land in every state; reset paints all spaces
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else if (bus.char_we) begin
      r_buf[bus.char_addr] <= bus.char_data;
    end
  end

  // State, counters and registered writer outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= PWRUP;
      r_phase     <= PH_SEND;
      r_pwr_cnt   <= '0;
      r_to_cnt    <= '0;
      r_init_idx  <= '0;
      r_char_idx  <= '0;
      r_wr_strb   <= 1'b0;
      r_wr_data   <= 8'h00;
      r_wr_rs     <= 1'b0;
      r_timeout   <= 1'b0;
      r_pending   <= 1'b0;
      r_rdy_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_pwr_cnt   <= w_pwr_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_char_idx  <= w_char_idx_nxt;
      r_wr_strb   <= w_strb_nxt;
      r_wr_data   <= w_data_nxt;
      r_wr_rs     <= w_rs_nxt;
      r_timeout   <= w_timeout_nxt;
      r_pending   <= w_pending_nxt;
      r_rdy_pulse <= w_rdy_pulse_nxt;
    end
  end

  // Byte selection, per-byte handshake and sequence advance
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_pwr_cnt_nxt   = r_pwr_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_init_idx_nxt  = r_init_idx;
    w_char_idx_nxt  = r_char_idx;
    w_strb_nxt      = 1'b0;
    w_data_nxt      = r_wr_data;
    w_rs_nxt        = r_wr_rs;
    w_timeout_nxt   = r_timeout;
    w_pending_nxt   = r_pending;
    w_rdy_pulse_nxt = 1'b0;
    w_byte_done     = 1'b0;
    w_tx_byte       = 8'h00;
    w_tx_rs         = 1'b0;
    w_sending       = (r_state == INIT)  || (r_state == ADDR1) ||
                      (r_state == LINE1) || (r_state == ADDR2) ||
                      (r_state == LINE2);

    case (r_state)
      INIT: begin
        case (r_init_idx)
          3'd0:    w_tx_byte = 8'h33;
          3'd1:    w_tx_byte = 8'h32;
          3'd2:    w_tx_byte = 8'h28;
          3'd3:    w_tx_byte = 8'h0C;
          3'd4:    w_tx_byte = 8'h06;
          default: w_tx_byte = 8'h01;
        endcase
      end
      ADDR1: w_tx_byte = 8'h80;
      ADDR2: w_tx_byte = 8'hC0;
      LINE1, LINE2: begin
        w_tx_byte = r_buf[r_char_idx];
        w_tx_rs   = 1'b1;
      end
      default: ;
    endcase

    // The byte is latched at strobe time, so a write to the same entry in
    // the strobe cycle only affects the buffer, not the byte on the wire.
    // The timeout counter spans both waits, measured from the strobe.
    if (w_sending) begin
      case (r_phase)
        PH_SEND: begin
          w_strb_nxt   = 1'b1;
          w_data_nxt   = w_tx_byte;
          w_rs_nxt     = w_tx_rs;
          w_to_cnt_nxt = '0;
          w_phase_nxt  = PH_WAIT_HI;
        end
        PH_WAIT_HI: begin
          w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
          if (bus.wr_busy) begin
            w_phase_nxt = PH_WAIT_LO;
          end else if (r_to_cnt >= c_TO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_byte_done   = 1'b1;
          end
        end
        PH_WAIT_LO: begin
          w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
          if (!bus.wr_busy) begin
            w_byte_done = 1'b1;
          end else if (r_to_cnt >= c_TO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_byte_done   = 1'b1;
          end
        end
        default: w_phase_nxt = PH_SEND;
      endcase
      if (w_byte_done) w_phase_nxt = PH_SEND;
    end

    case (r_state)
      PWRUP: begin
        if (r_pwr_cnt == c_PWR_LAST) begin
          w_pwr_cnt_nxt = '0;
          w_state_nxt   = INIT;
        end else begin
          w_pwr_cnt_nxt = r_pwr_cnt + c_PWR_W'(1);
        end
      end
      INIT: begin
        if (w_byte_done) begin
          if (r_init_idx == 3'd5) begin
            w_init_idx_nxt = '0;
            w_state_nxt    = IDLE;
          end else begin
            w_init_idx_nxt = r_init_idx + 3'd1;
          end
        end
      end
      IDLE: begin
`ifdef LCD_SEQ_AUTO_REFRESH_EN
        w_state_nxt = ADDR1;
`else
        if (bus.refresh || r_pending) w_state_nxt = ADDR1;
`endif
      end
      ADDR1: if (w_byte_done) w_state_nxt = LINE1;
      LINE1: begin
        if (w_byte_done) begin
          // 15 -> 16 rolls into the second line via its address command
          w_char_idx_nxt = r_char_idx + 5'd1;
          if (r_char_idx == 5'd15) w_state_nxt = ADDR2;
        end
      end
      ADDR2: if (w_byte_done) w_state_nxt = LINE2;
      LINE2: begin
        if (w_byte_done) begin
          // 31 -> 0 wrap closes the frame
          w_char_idx_nxt = r_char_idx + 5'd1;
          if (r_char_idx == 5'd31) begin
`ifdef LCD_SEQ_AUTO_REFRESH_EN
            w_state_nxt     = ADDR1;
            w_rdy_pulse_nxt = 1'b1;
`else
            w_state_nxt     = IDLE;
`endif
          end
        end
      end
      default: w_state_nxt = PWRUP;
    endcase

    // Requests outside IDLE merge into a single pending redraw
`ifdef LCD_SEQ_AUTO_REFRESH_EN
    w_pending_nxt = 1'b0;
`else
    if (bus.refresh && (r_state != IDLE)) w_pending_nxt = 1'b1;
`endif
    if ((w_state_nxt == ADDR1) && (r_state != ADDR1)) w_pending_nxt = 1'b0;
  end

  assign bus.wr_strb = r_wr_strb;
  assign bus.wr_data = r_wr_data;
  assign bus.wr_rs   = r_wr_rs;
  assign bus.timeout = r_timeout;
  assign bus.ready   = (r_state == IDLE) || r_rdy_pulse;

endmodule
`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lcd_sequencer
// Description : Directed self-checking bench for lcd_sequencer with a simple
//               Busy-handshake writer model and a strobe logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_sequencer;

  localparam int PWRUP_DLY = 300;
  localparam int TO_CYCLES = 250;
  localparam int BUSY_LEN  = 100;
  localparam int BYTE_BUDGET = BUSY_LEN + 20;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  lcd_sequencer_if bus ();

  lcd_sequencer #(
    .PWRUP_DLY (PWRUP_DLY),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Cycle counter
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Writer model: Busy rises 2 cycles after a strobe and stays high BUSY_LEN
  logic busy_en = 1'b1;
  int   w_cnt   = 0;
  always @(posedge Clk) begin
    if (Reset)                                   w_cnt <= 0;
    else if (bus.wr_strb)                        w_cnt <= 1;
    else if (w_cnt != 0 && w_cnt < 1 + BUSY_LEN) w_cnt <= w_cnt + 1;
    else                                         w_cnt <= 0;
  end
  assign bus.wr_busy = busy_en && (w_cnt >= 2);

  // Strobe logger: records {rs, data} and the cycle of every strobe
  logic [8:0] log_q [$];
  int         log_cyc [$];
  int         strb_dbl  = 0;
  logic       prev_strb = 1'b0;
  always @(negedge Clk) begin
    if (bus.wr_strb) begin
      log_q.push_back({bus.wr_rs, bus.wr_data});
      log_cyc.push_back(cyc);
    end
    if (bus.wr_strb && prev_strb) strb_dbl <= strb_dbl + 1;
    prev_strb <= bus.wr_strb;
  end

  logic [7:0] m_buf [32];
  logic [7:0] init_exp [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic buf_write(input int idx, input logic [7:0] ch);
    bus.char_we   = 1'b1;
    bus.char_addr = idx[4:0];
    bus.char_data = ch;
    tick(1);
    bus.char_we   = 1'b0;
    m_buf[idx]    = ch;
  endtask

  task automatic pulse_refresh();
    bus.refresh = 1'b1;
    tick(1);
    bus.refresh = 1'b0;
  endtask

  task automatic wait_size(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, log_q.size(), n);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int k = 0;
    while (!bus.ready && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_strb"},    {31'd0, bus.wr_strb}, 32'd0);
    check_eq({tag, "_data"},    {24'd0, bus.wr_data}, 32'd0);
    check_eq({tag, "_rs"},      {31'd0, bus.wr_rs},   32'd0);
    check_eq({tag, "_ready"},   {31'd0, bus.ready},   32'd0);
    check_eq({tag, "_timeout"}, {31'd0, bus.timeout}, 32'd0);
  endtask

  task automatic check_init(input int base, input string tag);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("%s[%0d]", tag, i), log_q[base + i], {1'b0, init_exp[i]});
  endtask

  task automatic check_frame(input int base, input string tag);
    logic [8:0] e;
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       e = {1'b0, 8'h80};
      else if (i < 17)  e = {1'b1, m_buf[i - 1]};
      else if (i == 17) e = {1'b0, 8'hC0};
      else              e = {1'b1, m_buf[i - 2]};
      check_eq($sformatf("%s[%0d]", tag, i), log_q[base + i], e);
    end
  endtask

  int t0, base, s, d;

  initial begin
    bus.char_we   = 1'b0;
    bus.char_addr = 5'd0;
    bus.char_data = 8'h00;
    bus.refresh   = 1'b0;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;

    // Reset state
    tick(3);
    check_reset_outputs("rst");

    // Power-up wait then init string
    Reset = 1'b0;
    t0 = cyc;
    wait_size(1, PWRUP_DLY + 20, "pwrup_first_strobe");
    d = log_cyc[0] - t0;
    check_eq("pwrup_delay_window", {31'd0, (d > PWRUP_DLY) && (d <= PWRUP_DLY + 3)}, 32'd1);
    wait_size(6, 6 * BYTE_BUDGET, "init_count");
    check_init(0, "init");
    wait_ready(BYTE_BUDGET, "init_ready");
    tick(20);
    check_eq("init_no_extra", log_q.size(), 6);

    // HELLO frame with 'A' in the last cell
    buf_write(0, "H");
    buf_write(1, "E");
    buf_write(2, "L");
    buf_write(3, "L");
    buf_write(4, "O");
    buf_write(31, "A");
    base = log_q.size();
    pulse_refresh();
    wait_size(base + 34, 34 * BYTE_BUDGET, "hello_count");
    check_frame(base, "hello");
    check_eq("hello_last", log_q[base + 33], {1'b1, 8'h41});
    wait_ready(BYTE_BUDGET, "hello_ready");

    // Write index 20 while line 1 is still going out
    base = log_q.size();
    pulse_refresh();
    wait_size(base + 5, 5 * BYTE_BUDGET, "z_line1");
    buf_write(20, "Z");
    wait_size(base + 34, 34 * BYTE_BUDGET, "z_count");
    check_frame(base, "z");
    check_eq("z_fifth_line2", log_q[base + 22], {1'b1, 8'h5A});
    wait_ready(BYTE_BUDGET, "z_ready");

    // Three refreshes mid-frame merge into one more frame
    base = log_q.size();
    pulse_refresh();
    wait_size(base + 3, 3 * BYTE_BUDGET, "merge_start");
    pulse_refresh();
    tick(10);
    pulse_refresh();
    tick(10);
    pulse_refresh();
    wait_size(base + 68, 68 * BYTE_BUDGET, "merge_count");
    wait_ready(BYTE_BUDGET, "merge_ready");
    tick(300);
    check_eq("merge_no_third", log_q.size(), base + 68);
    check_eq("merge_idle", {31'd0, bus.ready}, 32'd1);
    check_frame(base + 34, "merge2");

    // Writer never raises Busy
    busy_en = 1'b0;
    base = log_q.size();
    pulse_refresh();
    wait_size(base + 1, 10, "to_first");
    s = log_cyc[base];
    while (cyc < s + TO_CYCLES - 2) tick(1);
    check_eq("to_not_yet", {31'd0, bus.timeout}, 32'd0);
    while (cyc < s + TO_CYCLES + 1) tick(1);
    check_eq("to_set", {31'd0, bus.timeout}, 32'd1);
    wait_size(base + 2, 20, "to_advance");
    check_eq("to_next_byte", log_q[base + 1], {1'b1, m_buf[0]});
    d = log_cyc[base + 1] - s;
    check_eq("to_gap_window", {31'd0, (d >= TO_CYCLES) && (d <= TO_CYCLES + 3)}, 32'd1);
    wait_ready(34 * (TO_CYCLES + 5), "to_ready");
    check_eq("to_frame_len", log_q.size(), base + 34);
    check_eq("to_sticky", {31'd0, bus.timeout}, 32'd1);
    busy_en = 1'b1;
    tick(150);

    // Reset during line 1 byte 7, colliding with a write and a refresh
    base = log_q.size();
    pulse_refresh();
    wait_size(base + 8, 8 * BYTE_BUDGET, "rst_mid_reach");
    Reset         = 1'b1;
    bus.char_we   = 1'b1;
    bus.char_addr = 5'd3;
    bus.char_data = "Q";
    bus.refresh   = 1'b1;
    tick(1);
    check_reset_outputs("rst_mid");
    Reset       = 1'b0;
    bus.char_we = 1'b0;
    bus.refresh = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    base = log_q.size();
    tick(50);
    check_eq("rst_no_strobe", log_q.size(), base);
    pulse_refresh();
    wait_size(base + 1, PWRUP_DLY + 20, "rst_first_strobe");
    d = log_cyc[base] - t0;
    check_eq("rst_pwrup_window", {31'd0, (d > PWRUP_DLY) && (d <= PWRUP_DLY + 3)}, 32'd1);
    wait_size(base + 6, 6 * BYTE_BUDGET, "rst_init_count");
    check_init(base, "rst_init");
    wait_size(base + 40, 34 * BYTE_BUDGET + BYTE_BUDGET, "rst_frame_count");
    check_frame(base + 6, "rst_blank");
    wait_ready(BYTE_BUDGET, "rst_ready");

    check_eq("strobe_single_cycle", strb_dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
